cpu_run_seq: RTL and testbench
==============================

Name: cpu_run_seq

Overview:
Host-driven run sequencer for the soft CPU. It takes commands from the HPS bridge over a valid/ready handshake and drives the CPU's reset and clock-enable. Supported commands are reset, free-run, run-N-cycles (step) and stop. It reports state, halt cause, enabled-cycle count and completion to the HPS status registers.

Parameters:
CNT_W, 32, width of step argument and cycle counter
RST_CYCLES, 16, cycles cpu_rst_n held low in RESET (>=1)
WDOG_CYCLES, 1000000, RUN timeout (only with CPU_RUN_WDOG_EN)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 RESET, 01 RUN, 10 STEP, 11 STOP
cmd_arg  in  CNT_W  STEP cycle count; ignored for other ops
cpu_halt  in  1  CPU halt request, level, sampled only in RUN/STEP
cpu_rst_n  out  1  CPU reset, active-low
cpu_en  out  1  CPU clock-enable
state  out  3  0 IDLE, 1 RESET, 2 HALTED, 3 RUN, 4 STEP
alive  out  1  equals cpu_en
cycles  out  CNT_W  enabled cycles since last RESET, saturating
halt_cause  out  2  00 none, 01 cpu_halt, 10 host STOP, 11 step complete
done  out  1  1-cycle pulse on entering HALTED from RUN/STEP
cmd_err  out  1  1-cycle pulse after an illegal accepted command

Behaviour:
- Async reset: state=IDLE, cpu_rst_n=0, cpu_en=0, cycles=0, halt_cause=00, done=0, cmd_err=0, internal step/reset counters=0.
- cmd_ready = (state != RESET); combinational from state. Every accepted command takes effect on the next edge.
- cpu_rst_n = 0 in IDLE and RESET, 1 otherwise.
- cpu_en = 1 iff state is RUN or STEP. Both are decoded from the registered state, so there are no glitches.
- IDLE:
  - RESET goes to RESET.
  - RUN, STEP and STOP are illegal: pulse cmd_err and stay in IDLE.
- RESET:
  - Load the counter with RST_CYCLES and stay exactly RST_CYCLES cycles.
  - Clear cycles and halt_cause on entry.
  - Then go to HALTED. No done pulse.
- HALTED:
  - RUN goes to RUN.
  - STEP with cmd_arg>0 goes to STEP, remaining=cmd_arg.
  - STEP with cmd_arg==0 pulses cmd_err and stays in HALTED.
  - RESET goes to RESET.
  - STOP pulses cmd_err.
  - halt_cause holds its last value.
- RUN:
  - cycles += 1 per cycle, saturating at all-ones.
  - Exit priority, highest first:
    - accepted RESET goes to RESET.
    - cpu_halt=1 goes to HALTED, cause 01.
    - accepted STOP goes to HALTED, cause 10.
  - Accepted RUN/STEP pulses cmd_err; state is unchanged.
- STEP:
  - Same as RUN, plus remaining decrements each cycle.
  - When remaining==1 with no higher-priority event, go to HALTED with cause 11. cpu_en is therefore high for exactly cmd_arg cycles.
  - cpu_halt in the final step cycle wins: cause 01.
- done:
  - Registered. It is high during the first HALTED cycle when entered from RUN or STEP.
  - It is not pulsed on a RESET-command exit.
- cmd_err: registered, high for one cycle after the illegal accept. Never asserted for legal commands.
- Invalid state encodings (5-7) go to IDLE.

Optional Feature:
- Macro CPU_RUN_WDOG_EN.
- With the macro:
  - Add port wdog_trip (out, 1), reset 0.
  - A counter clears on RUN entry and increments each RUN cycle.
  - On reaching WDOG_CYCLES with no higher-priority exit: go to HALTED, cause 10, done pulse, and set wdog_trip (sticky, cleared only on entry to RESET).
  - STEP is not watched.
- Without the macro: no port, no counter; RUN is unbounded.

Test Plan:
- Reset, then RESET command: cpu_rst_n low exactly 16 cycles, then state=2, cycles=0, cmd_ready low throughout RESET.
- HALTED, STEP with arg=5: cpu_en high exactly 5 cycles, cycles=5, halt_cause=11, done one pulse, state=2.
- RUN, cpu_halt raised after 100 cycles: state=2 next edge, cause=01, cycles=100, done pulse. Repeat with STOP and cpu_halt in the same cycle: cause=01.
- IDLE RUN, HALTED STOP, STEP arg=0, and RUN while running: each gives cmd_err single pulse with state unchanged.
- RESET command mid-STEP (arg=1000, at cycle 10): state=1, cpu_rst_n=0, cycles cleared, no done pulse. Also assert rst_n mid-RUN: all outputs return to reset values immediately.
- With CPU_RUN_WDOG_EN and WDOG_CYCLES=50, RUN with no halt: HALTED after 50 cycles, cause=10, wdog_trip=1 until the next RESET command.

Source files
------------

// File: rtl/cpu_run_seq.sv
// cpu_run_seq: host-driven run sequencer for the soft CPU.
// Accepts RESET / RUN / STEP / STOP commands over a valid/ready handshake.
// It drives the CPU reset and clock-enable, and reports state, halt cause,
// the enabled-cycle count and completion pulses.
// Optional RUN watchdog: define CPU_RUN_WDOG_EN to add the WDOG_CYCLES
// parameter, the wdog_trip port and the RUN timeout.
module cpu_run_seq #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 16
`ifdef CPU_RUN_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 1000000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             cpu_halt,
  output logic             cpu_rst_n,
  output logic             cpu_en,
  output logic [2:0]       state,
  output logic             alive,
  output logic [CNT_W-1:0] cycles,
  output logic [1:0]       halt_cause,
  output logic             done,
  output logic             cmd_err
`ifdef CPU_RUN_WDOG_EN
  ,
  output logic             wdog_trip
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_HALTED = 3'd2,
    ST_RUN    = 3'd3,
    ST_STEP   = 3'd4
  } state_e;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HALT = 2'b01;
  localparam logic [1:0] CAUSE_HOST = 2'b10;
  localparam logic [1:0] CAUSE_STEP = 2'b11;

  localparam int unsigned      RST_W    = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [1:0]       halt_cause_q, halt_cause_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             done_q, done_d;
  logic             cmd_err_q, cmd_err_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic             cpu_en_q, cpu_en_d;
  logic             accept_s;
  logic             wdog_hit_s;

  assign cmd_ready  = (state_q != ST_RESET);
  assign accept_s   = cmd_valid & cmd_ready;
  assign state      = state_q;
  assign cycles     = cycles_q;
  assign halt_cause = halt_cause_q;
  assign done       = done_q;
  assign cmd_err    = cmd_err_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign cpu_en     = cpu_en_q;
  assign alive      = cpu_en_q;

  // Command decode, state transitions and counter updates
  always_comb begin
    state_d      = state_q;
    cycles_d     = cycles_q;
    halt_cause_d = halt_cause_q;
    rem_d        = rem_q;
    rst_cnt_d    = rst_cnt_q;
    cmd_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (cmd_op == OP_RESET) begin
            state_d      = ST_RESET;
            rst_cnt_d    = RST_LOAD;
            cycles_d     = CNT_W'(0);
            halt_cause_d = CAUSE_NONE;
          end else begin
            cmd_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESET: begin
        // counter was loaded with RST_CYCLES on entry; leave on its last cycle
        if (rst_cnt_q <= RST_W'(1)) begin
          state_d   = ST_HALTED;
          rst_cnt_d = RST_W'(0);
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end
      ST_HALTED: begin
        if (accept_s) begin
          case (cmd_op)
            OP_RESET: begin
              state_d      = ST_RESET;
              rst_cnt_d    = RST_LOAD;
              cycles_d     = CNT_W'(0);
              halt_cause_d = CAUSE_NONE;
            end
            OP_RUN: begin
              state_d = ST_RUN;
            end
            OP_STEP: begin
              if (cmd_arg != CNT_W'(0)) begin
                state_d = ST_STEP;
                rem_d   = cmd_arg;
              end else begin
                cmd_err_d = 1'b1;
              end
            end
            default: begin
              // STOP while already halted
              cmd_err_d = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RUN, ST_STEP: begin
        if (cycles_q != CNT_MAX) begin
          cycles_d = cycles_q + CNT_W'(1);
        end else begin
          cycles_d = cycles_q;
        end
        if (state_q == ST_STEP) begin
          rem_d = rem_q - CNT_W'(1);
        end else begin
          rem_d = rem_q;
        end
        // exit priority: host RESET, CPU halt, host STOP, step done, watchdog
        if (accept_s && (cmd_op == OP_RESET)) begin
          state_d      = ST_RESET;
          rst_cnt_d    = RST_LOAD;
          cycles_d     = CNT_W'(0);
          halt_cause_d = CAUSE_NONE;
        end else if (cpu_halt) begin
          state_d      = ST_HALTED;
          halt_cause_d = CAUSE_HALT;
        end else if (accept_s && (cmd_op == OP_STOP)) begin
          state_d      = ST_HALTED;
          halt_cause_d = CAUSE_HOST;
        end else if ((state_q == ST_STEP) && (rem_q == CNT_W'(1))) begin
          state_d      = ST_HALTED;
          halt_cause_d = CAUSE_STEP;
        end else if (wdog_hit_s) begin
          state_d      = ST_HALTED;
          halt_cause_d = CAUSE_HOST;
        end else begin
          state_d = state_q;
        end
        if (accept_s && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) begin
          cmd_err_d = 1'b1;
        end else begin
          cmd_err_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the CPU controls come straight from flops
  always_comb begin
    done_d      = (state_d == ST_HALTED) &&
                  ((state_q == ST_RUN) || (state_q == ST_STEP));
    cpu_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    cpu_rst_n_d = (state_d != ST_IDLE) && (state_d != ST_RESET);
  end

  // Sequencer state and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cycles_q     <= CNT_W'(0);
      halt_cause_q <= CAUSE_NONE;
      rem_q        <= CNT_W'(0);
      rst_cnt_q    <= RST_W'(0);
      done_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      cpu_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycles_q     <= cycles_d;
      halt_cause_q <= halt_cause_d;
      rem_q        <= rem_d;
      rst_cnt_q    <= rst_cnt_d;
      done_q       <= done_d;
      cmd_err_q    <= cmd_err_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_en_q     <= cpu_en_d;
    end
  end

`ifdef CPU_RUN_WDOG_EN
  localparam int unsigned     WD_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic            wdog_trip_q, wdog_trip_d;
  logic            wdog_take_s;

  assign wdog_trip = wdog_trip_q;

  // Watchdog expiry: this is the WDOG_CYCLES-th consecutive RUN cycle
  always_comb begin
    wdog_hit_s = (state_q == ST_RUN) && (wdog_cnt_q == WD_LAST);
  end

  // Watchdog counter and sticky trip flag (trip only when no higher exit won)
  always_comb begin
    wdog_take_s = wdog_hit_s && (state_d == ST_HALTED) && !cpu_halt &&
                  !(accept_s && (cmd_op == OP_STOP));
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      wdog_cnt_d = WD_W'(0);
    end else if (state_q == ST_RUN) begin
      wdog_cnt_d = wdog_cnt_q + WD_W'(1);
    end else begin
      wdog_cnt_d = wdog_cnt_q;
    end
    if ((state_d == ST_RESET) && (state_q != ST_RESET)) begin
      wdog_trip_d = 1'b0;
    end else if (wdog_take_s) begin
      wdog_trip_d = 1'b1;
    end else begin
      wdog_trip_d = wdog_trip_q;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q  <= WD_W'(0);
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end
`else
  // RUN is unbounded without the watchdog
  always_comb begin
    wdog_hit_s = 1'b0;
  end
`endif

endmodule

// File: tb/tb_cpu_run_seq.sv
// tb_cpu_run_seq: directed bench for cpu_run_seq with a behavioural model
// compared on every falling clock edge plus hand-computed checkpoints.
module tb_cpu_run_seq;
  localparam int CNT_W      = 10;
  localparam int RST_CYCLES = 16;
`ifdef CPU_RUN_WDOG_EN
  localparam int WD      = 50;
  localparam int HALT_AT = 30;
`else
  localparam int HALT_AT = 100;
`endif
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_arg = '0;
  logic             cpu_halt = 1'b0;
  logic             cmd_ready, cpu_rst_n, cpu_en, alive, done, cmd_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycles;
  logic [1:0]       halt_cause;
`ifdef CPU_RUN_WDOG_EN
  logic             wdog_trip;
`endif

  int checks = 0;
  int errors = 0;
  int en_tot = 0, done_tot = 0, err_tot = 0, rst_tot = 0, rdy_rst_tot = 0;

  cpu_run_seq #(
    .CNT_W(CNT_W),
    .RST_CYCLES(RST_CYCLES)
`ifdef CPU_RUN_WDOG_EN
    ,
    .WDOG_CYCLES(WD)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_arg(cmd_arg),
    .cpu_halt(cpu_halt),
    .cpu_rst_n(cpu_rst_n),
    .cpu_en(cpu_en),
    .state(state),
    .alive(alive),
    .cycles(cycles),
    .halt_cause(halt_cause),
    .done(done),
    .cmd_err(cmd_err)
`ifdef CPU_RUN_WDOG_EN
    ,
    .wdog_trip(wdog_trip)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // st: 0 idle, 1 reset, 2 halted, 3 run, 4 step
  typedef struct packed {
    logic [2:0]       st;
    logic [1:0]       cause;
    logic             done;
    logic             err;
    logic             trip;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] left;
    logic [31:0]      rsp;
    logic [31:0]      run_len;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t enter_reset(mdl_t x);
    x.st = 3'd1; x.cyc = '0; x.cause = 2'd0; x.rsp = 0; x.trip = 1'b0;
    return x;
  endfunction

  function automatic mdl_t halt_with(mdl_t x, logic [1:0] c);
    x.st = 3'd2; x.cause = c; x.done = 1'b1;
    return x;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m0, logic v, logic [1:0] op,
                                    logic [CNT_W-1:0] arg, logic halt);
    mdl_t n = m0;
    logic acc = v && (m0.st != 3'd1);
    n.done = 1'b0;
    n.err  = 1'b0;
    if (m0.st == 3'd0) begin
      if (acc && op == 2'd0) n = enter_reset(n);
      else if (acc) n.err = 1'b1;
    end else if (m0.st == 3'd1) begin
      n.rsp = m0.rsp + 1;
      if (n.rsp == RST_CYCLES) n.st = 3'd2;
    end else if (m0.st == 3'd2) begin
      if (acc) begin
        case (op)
          2'd0: n = enter_reset(n);
          2'd1: begin n.st = 3'd3; n.run_len = 0; end
          2'd2: if (arg != 0) begin n.st = 3'd4; n.left = arg; end else n.err = 1'b1;
          default: n.err = 1'b1;
        endcase
      end
    end else begin
      n.cyc     = (m0.cyc == CMAX) ? CMAX : m0.cyc + 1'b1;
      n.left    = m0.left - 1'b1;
      n.run_len = m0.run_len + 1;
      n.err     = acc && (op == 2'd1 || op == 2'd2);
      if (acc && op == 2'd0) n = enter_reset(n);
      else if (halt) n = halt_with(n, 2'd1);
      else if (acc && op == 2'd3) n = halt_with(n, 2'd2);
      else if (m0.st == 3'd4 && m0.left == 1) n = halt_with(n, 2'd3);
`ifdef CPU_RUN_WDOG_EN
      else if (m0.st == 3'd3 && n.run_len == WD) begin n = halt_with(n, 2'd2); n.trip = 1'b1; end
`endif
    end
    return n;
  endfunction

  // model advances on the same edges as the design
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= mdl_next(m, cmd_valid, cmd_op, cmd_arg, cpu_halt);
  end

  // per-cycle comparison against the model, plus event tallies
  always @(negedge clk) begin
    chk("state", state, m.st);
    chk("cmd_ready", cmd_ready, m.st != 3'd1);
    chk("cpu_rst_n", cpu_rst_n, !(m.st == 3'd0 || m.st == 3'd1));
    chk("cpu_en", cpu_en, (m.st == 3'd3 || m.st == 3'd4));
    chk("alive", alive, (m.st == 3'd3 || m.st == 3'd4));
    chk("cycles", cycles, m.cyc);
    chk("halt_cause", halt_cause, m.cause);
    chk("done", done, m.done);
    chk("cmd_err", cmd_err, m.err);
`ifdef CPU_RUN_WDOG_EN
    chk("wdog_trip", wdog_trip, m.trip);
`endif
    en_tot      <= en_tot + (cpu_en ? 1 : 0);
    done_tot    <= done_tot + (done ? 1 : 0);
    err_tot     <= err_tot + (cmd_err ? 1 : 0);
    rst_tot     <= rst_tot + (state == 3'd1 ? 1 : 0);
    rdy_rst_tot <= rdy_rst_tot + ((state == 3'd1 && cmd_ready) ? 1 : 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cmd(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(posedge clk); #2;
    cmd_valid = 1'b0; cmd_arg = '0;
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
    int n = 0;
    while (state !== tgt && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, state, tgt);
  endtask

  task automatic do_reset();
    cmd(2'd0, '0);
    wait_state(3'd2, RST_CYCLES + 8, "reset_to_halted");
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_state"}, state, 3'd0);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
    chk({tag, "_cpu_en"}, cpu_en, 1'b0);
    chk({tag, "_cycles"}, cycles, 0);
    chk({tag, "_cause"}, halt_cause, 2'd0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, cmd_err, 1'b0);
    chk({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e0, d0, r0, q0, n0;
    #1;
    reset_literals("por");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // illegal RUN in IDLE
    e0 = err_tot;
    cmd(2'd1, '0);
    cyc_wait(3);
    chk("idle_run_err_pulses", err_tot - e0, 1);
    chk("idle_run_state", state, 3'd0);

    // RESET command: exactly 16 cycles in RESET, never ready
    r0 = rst_tot; q0 = rdy_rst_tot;
    do_reset();
    chk("reset_len", rst_tot - r0, RST_CYCLES);
    chk("reset_ready_low", rdy_rst_tot - q0, 0);
    chk("reset_cycles", cycles, 0);
    chk("reset_cpu_rst_n", cpu_rst_n, 1'b1);

    // STEP 5
    n0 = en_tot; d0 = done_tot;
    cmd(2'd2, 10'd5);
    wait_state(3'd2, 20, "step5_halted");
    cyc_wait(3);
    chk("step5_en_cycles", en_tot - n0, 5);
    chk("step5_cycles", cycles, 5);
    chk("step5_cause", halt_cause, 2'd3);
    chk("step5_done", done_tot - d0, 1);

    // STEP 1 boundary
    n0 = en_tot;
    cmd(2'd2, 10'd1);
    cyc_wait(3);
    chk("step1_en_cycles", en_tot - n0, 1);
    chk("step1_cause", halt_cause, 2'd3);
    chk("step1_cycles", cycles, 6);

    // cpu_halt on the final STEP cycle wins
    cmd(2'd2, 10'd3);
    cyc_wait(2);
    cpu_halt = 1'b1;
    cyc_wait(1);
    cpu_halt = 1'b0;
    chk("step_last_halt_state", state, 3'd2);
    chk("step_last_halt_cause", halt_cause, 2'd1);

    // RUN, cpu_halt in the HALT_AT-th cycle
    do_reset();
    n0 = en_tot; d0 = done_tot;
    cmd(2'd1, '0);
    cyc_wait(HALT_AT - 1);
    cpu_halt = 1'b1;
    cyc_wait(1);
    cpu_halt = 1'b0;
    chk("run_halt_state", state, 3'd2);
    chk("run_halt_cause", halt_cause, 2'd1);
    chk("run_halt_cycles", cycles, HALT_AT);
    cyc_wait(3);
    chk("run_halt_en", en_tot - n0, HALT_AT);
    chk("run_halt_done", done_tot - d0, 1);

    // STOP and cpu_halt together: halt wins
    cmd(2'd1, '0);
    cyc_wait(3);
    cpu_halt = 1'b1;
    cmd(2'd3, '0);
    cpu_halt = 1'b0;
    chk("stop_vs_halt_cause", halt_cause, 2'd1);

    // illegal commands in HALTED and RUN
    e0 = err_tot;
    cmd(2'd3, '0);
    cyc_wait(3);
    chk("halted_stop_err", err_tot - e0, 1);
    chk("halted_stop_state", state, 3'd2);
    e0 = err_tot;
    cmd(2'd2, 10'd0);
    cyc_wait(3);
    chk("step0_err", err_tot - e0, 1);
    chk("step0_state", state, 3'd2);
    cmd(2'd1, '0);
    e0 = err_tot;
    cmd(2'd1, '0);
    cyc_wait(3);
    chk("run_run_err", err_tot - e0, 1);
    chk("run_run_state", state, 3'd3);
    d0 = done_tot;
    cmd(2'd3, '0);
    cyc_wait(2);
    chk("stop_cause", halt_cause, 2'd2);
    chk("stop_done", done_tot - d0, 1);

    // RESET command mid-STEP at cycle 10
    do_reset();
    d0 = done_tot;
    cmd(2'd2, 10'd1000);
    cyc_wait(9);
    chk("midstep_cycles_before", cycles, 9);
    cmd(2'd0, '0);
    chk("midstep_state", state, 3'd1);
    chk("midstep_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("midstep_cycles", cycles, 0);
    wait_state(3'd2, RST_CYCLES + 8, "midstep_recover");
    chk("midstep_no_done", done_tot - d0, 0);

`ifndef CPU_RUN_WDOG_EN
    // cycle counter saturation
    cmd(2'd1, '0);
    cyc_wait(1100);
    cmd(2'd3, '0);
    chk("sat_cycles", cycles, 10'd1023);
`else
    // watchdog: 50 RUN cycles then HALTED, cause 10, sticky trip
    do_reset();
    n0 = en_tot; d0 = done_tot;
    cmd(2'd1, '0);
    wait_state(3'd2, 80, "wdog_halted");
    cyc_wait(2);
    chk("wdog_en", en_tot - n0, WD);
    chk("wdog_cause", halt_cause, 2'd2);
    chk("wdog_trip_set", wdog_trip, 1'b1);
    chk("wdog_done", done_tot - d0, 1);
    cmd(2'd1, '0);
    cmd(2'd3, '0);
    chk("wdog_trip_sticky", wdog_trip, 1'b1);
    cmd(2'd0, '0);
    chk("wdog_trip_clr", wdog_trip, 1'b0);
    wait_state(3'd2, RST_CYCLES + 8, "wdog_reset_done");
`endif

    // async reset mid-RUN
    cmd(2'd1, '0);
    cyc_wait(5);
    rst_n = 1'b0;
    #1;
    reset_literals("async");
    #20;
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc_wait(2);
    chk("post_async_state", state, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
